cpu6_bus_responder: RTL
=======================

# cpu6_bus_responder

Memory-side responder for the CPU6 address/data bus: decodes each CPU-initiated read or write cycle, services it from on-chip byte RAM or a memory-mapped console port, and signals completion with a one-cycle `ready` pulse after a programmable number of wait states. It sits directly across the bus from CPU6 in the top-level and CPU test bench. It replaces a bare memory model with a timed, handshaked target that includes a buffered console output channel.

## Interface
Parameters:
- `RAM_BYTES`, 4096: RAM size; covers addresses 0 .. RAM_BYTES-1. Power of two, at most 32768.
- `WAIT_STATES`, 1: extra cycles inserted before an access completes. Range 0..7.
- `CONSOLE_ADDR`, 16'hF200: console data/status register address.
- `FIFO_DEPTH`, 4: console output FIFO entries. Power of two, at least 2.

Ports:
- `clock`  in  1  single system clock; all state on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `addressBus`  in  16  byte address from CPU6; sampled at cycle start.
- `dataIn`  in  8  CPU write data; sampled at cycle start.
- `readEnable`  in  1  CPU read request; held until `ready`.
- `writeEnable`  in  1  CPU write request; held until `ready`.
- `dataOut`  out  8  read data; valid in the `ready` cycle and held until the next read completes.
- `ready`  out  1  one-cycle completion pulse.
- `consoleData`  out  8  FIFO head byte.
- `consoleValid`  out  1  FIFO non-empty.
- `consoleReady`  in  1  sink accepts `consoleData` when both valid and ready are high.

## Operation
- States: IDLE, WAIT, ACCESS, STALL.
- IDLE:
  - On `readEnable|writeEnable`, latch address, data, and direction.
  - Write wins if both strobes are high.
  - Go to WAIT if `WAIT_STATES`>0, else ACCESS.
- WAIT: count down `WAIT_STATES` cycles, then go to ACCESS.
- ACCESS: perform the access, pulse `ready`, return to IDLE.
  - Strobes are re-sampled only in IDLE. The cycle after `ready` is always IDLE, so back-to-back requests are separated by at least one cycle.
- Decode in ACCESS:
  - addr < RAM_BYTES:
    - Read: `dataOut` = RAM[addr].
    - Write: RAM[addr] = data.
  - addr == CONSOLE_ADDR:
    - Write pushes the byte into the FIFO.
    - Read returns status: bit0 = FIFO not full, bit1 = FIFO empty, bits7:2 = 0.
  - Any other address:
    - Read returns 8'hFF.
    - Write is discarded but still completes with `ready`.
- Console write with FIFO full: go to STALL instead of completing.
  - STALL holds until a pop occurs.
  - The push and `ready` happen in the same cycle as that pop, and the state returns to IDLE.
- FIFO behaviour:
  - A push and a pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - Read and write ordering is preserved.
- Reset:
  - Outputs: `ready`=0, `dataOut`=8'h00, `consoleValid`=0; `consoleData` is don't-care while `consoleValid` is low.
  - FIFO emptied; state returns to IDLE.
  - RAM contents are not cleared.
  - Reset during WAIT or STALL aborts the access: no RAM write, no FIFO push, no `ready`.

## Timing
- Request sampled in IDLE at edge N.
- `ready` high during cycle N+1+WAIT_STATES: latency 1 with 0 wait states, 2 with the default.
- STALL adds one cycle per cycle the FIFO stays full.
- RAM write and FIFO push take effect at the edge ending the `ready` cycle. A read issued next sees the new value.
- `consoleValid` rises the cycle after the first push into an empty FIFO.
- A pop takes effect at the edge where valid and ready are both high; `consoleData` shows the next entry the following cycle.
- Strobe deasserted before `ready`: the latched request still completes, since it was already captured.

## Structure
- Package `cpu6_bus_pkg` holds:
  - the state enum (IDLE/WAIT/ACCESS/STALL);
  - the `CONSOLE_ADDR` default;
  - status bit positions `STAT_NOT_FULL`=0, `STAT_EMPTY`=1;
  - the unmapped read value 8'hFF.
- Sub-module `byte_fifo`: parameterised depth, push/pop/full/empty/count, synchronous reset. It is instantiated once for the console path.
- RAM is an inferred single-port array inside the responder.

## Test plan
- Write 8'hA5 to 16'h0010, then read 16'h0010: `ready` comes 2 cycles after each strobe, and read `dataOut`=8'hA5.
- Read 16'h9000 (unmapped): `dataOut`=8'hFF. Write to 16'h9000, then read: still 8'hFF.
- Hold `consoleReady`=0 and write 5 bytes to `CONSOLE_ADDR` (depth 4): the 4th completes normally and the 5th stalls. Raise `consoleReady`: the 5th completes in the first pop cycle, and bytes drain in order.
- Read `CONSOLE_ADDR` with an empty FIFO: 8'h03. With 4 entries: 8'h00.
- Assert both strobes to address 16'h0020 with data 8'h3C: treated as a write, and a subsequent read of 16'h0020 returns 8'h3C.
- Assert `reset` during WAIT of a write to 16'h0030 (prior value 8'h11): no `ready`, RAM[0x30] stays 8'h11, outputs return to reset values next cycle.

Source files
------------

// File: rtl/cpu6_bus_pkg.sv
// Shared types and constants for the CPU6 bus responder: FSM states, console
// register defaults and the status byte layout.
package cpu6_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACCESS,
      ST_STALL
   } bus_state_e;

   localparam logic [15:0] CONSOLE_ADDR_DFLT = 16'hF200;
   localparam int          STAT_NOT_FULL     = 0;
   localparam int          STAT_EMPTY        = 1;
   localparam logic [7:0]  UNMAPPED_RD       = 8'hFF;

   function automatic logic [7:0] console_status(input logic not_full, input logic empty);
      logic [7:0] s;
      s                = 8'h00;
      s[STAT_NOT_FULL] = not_full;
      s[STAT_EMPTY]    = empty;
      return s;
   endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO with occupancy count. A push is accepted while full
// only when a pop happens in the same cycle, so the count is unchanged.
module byte_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int            PW       = $clog2(DEPTH);
   localparam logic [PW:0]   FULL_CNT = DEPTH[PW:0];

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW:0]      count_q, count_d;
   logic             push_en, pop_en;

   assign full     = (count_q == FULL_CNT);
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign pop_data = mem_q[rd_ptr_q];

   always_comb begin
      pop_en   = pop && !empty;
      push_en  = push && (!full || pop_en);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_en, pop_en})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push_en) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/cpu6_bus_responder.sv
// Bus target for CPU6: latches a request, inserts wait states, then services
// it from byte RAM, the console FIFO/status register, or the unmapped space.
module cpu6_bus_responder
   import cpu6_bus_pkg::*;
#(
   parameter int          RAM_BYTES    = 4096,
   parameter int          WAIT_STATES  = 1,
   parameter logic [15:0] CONSOLE_ADDR = CONSOLE_ADDR_DFLT,
   parameter int          FIFO_DEPTH   = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] addressBus,
   input  logic [7:0]  dataIn,
   input  logic        readEnable,
   input  logic        writeEnable,
   output logic [7:0]  dataOut,
   output logic        ready,
   output logic [7:0]  consoleData,
   output logic        consoleValid,
   input  logic        consoleReady
);

   localparam int              AW        = $clog2(RAM_BYTES);
   localparam int              CNTW      = $clog2(FIFO_DEPTH) + 1;
   localparam logic [16:0]     RAM_LIMIT = 17'(RAM_BYTES);
   localparam logic [2:0]      WAIT_LOAD = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
   localparam logic [CNTW-1:0] FIFO_FULL = CNTW'(FIFO_DEPTH);

   bus_state_e  state_q, state_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  data_q, data_d;
   logic        wr_q, wr_d;
   logic [2:0]  wait_cnt_q, wait_cnt_d;
   logic [7:0]  dout_q, dout_d;

   logic [7:0]      ram_q [RAM_BYTES];
   logic [AW-1:0]   addr_idx;
   logic            in_ram, is_con, ram_we;
   logic [7:0]      rd_val;
   logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [CNTW-1:0] fifo_count;

   assign addr_idx     = addr_q[AW-1:0];
   assign in_ram       = ({1'b0, addr_q} < RAM_LIMIT);
   assign is_con       = (addr_q == CONSOLE_ADDR);
   assign fifo_pop     = consoleReady && !fifo_empty;
   assign consoleValid = !fifo_empty;

   byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_console_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (data_q),
      .pop       (fifo_pop),
      .pop_data  (consoleData),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      data_d     = data_q;
      wr_d       = wr_q;
      wait_cnt_d = wait_cnt_q;
      dout_d     = dout_q;
      dataOut    = dout_q;
      ready      = 1'b0;
      fifo_push  = 1'b0;
      ram_we     = 1'b0;

      if (in_ram)      rd_val = ram_q[addr_idx];
      else if (is_con) rd_val = console_status(fifo_count != FIFO_FULL, fifo_count == '0);
      else             rd_val = UNMAPPED_RD;

      case (state_q)
         ST_IDLE: begin
            if (readEnable || writeEnable) begin
               addr_d     = addressBus;
               data_d     = dataIn;
               wr_d       = writeEnable;
               wait_cnt_d = WAIT_LOAD;
               state_d    = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
            end
         end
         ST_WAIT: begin
            if (wait_cnt_q == 3'd0) state_d = ST_ACCESS;
            else                    wait_cnt_d = wait_cnt_q - 1'b1;
         end
         ST_ACCESS: begin
            if (wr_q && is_con && fifo_full) begin
               state_d = ST_STALL;
            end else begin
               ready   = 1'b1;
               state_d = ST_IDLE;
               if (wr_q) begin
                  ram_we    = in_ram;
                  fifo_push = is_con;
               end else begin
                  dout_d  = rd_val;
                  dataOut = rd_val;
               end
            end
         end
         ST_STALL: begin
            // The held byte slips into the slot freed by this cycle's pop.
            if (fifo_pop) begin
               fifo_push = 1'b1;
               ready     = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         dout_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         dout_q  <= dout_d;
      end
   end

   always_ff @(posedge clock) begin
      addr_q     <= addr_d;
      data_q     <= data_d;
      wr_q       <= wr_d;
      wait_cnt_q <= wait_cnt_d;
   end

   always_ff @(posedge clock) begin
      if (ram_we) ram_q[addr_idx] <= data_q;
   end

endmodule
